ber_run_ctrl: RTL

BER_RUN_CTRL -- requirements
Module: ber_run_ctrl

---
 rtl/ber_run_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ber_run_ctrl.sv
// Run controller for a parallel BER measurement system: clears the counters, runs until a
// threshold or abort, drains the pipeline, then snapshots the totals for readback.
module ber_run_ctrl #(
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [63:0] target_frame_errors,
    input  logic [63:0] max_bits,
    input  logic [63:0] total_bits,
    input  logic [63:0] total_bit_errors_pre,
    input  logic [63:0] total_bit_errors_post,
    input  logic [63:0] total_frames,
    input  logic [63:0] total_frame_errors,
    output logic        sys_en,
    output logic        sys_rstn,
    output logic        busy,
    output logic        done,
    output logic [1:0]  stop_reason,
    input  logic [2:0]  rd_addr,
    output logic [63:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_SNAP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [63:0] cyc_q, cyc_d;
    logic [1:0]  reason_q, reason_d;
    logic [63:0] snap_q [6];
    logic [63:0] rd_q, rd_d;
    logic        sys_en_q, sys_rstn_q, busy_q, done_q;
    logic        hit_fe, hit_b;

    assign hit_fe = (target_frame_errors != '0) && (total_frame_errors >= target_frame_errors);
    assign hit_b  = (max_bits != '0) && (total_bits >= max_bits);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + 8'd1;
        cyc_d    = cyc_q;
        reason_d = reason_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_CLEAR;
                    reason_d = 2'b00;
                    cyc_d    = '0;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d  = S_DRAIN;
                    reason_d = 2'b11;
                end else if (phase_q == 8'(CLEAR_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cyc_q != '1) cyc_d = cyc_q + 64'd1;
                if (abort || hit_fe || hit_b) begin
                    state_d  = S_DRAIN;
                    reason_d = abort ? 2'b11 : (hit_fe ? 2'b01 : 2'b10);
                end
            end
            S_DRAIN: begin
                if (phase_q == 8'(DRAIN_CYCLES - 1)) state_d = S_SNAP;
            end
            S_SNAP:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        // Phase counter restarts on every state change so each timed state counts from zero.
        if (state_d != state_q) phase_d = '0;
    end

    always_comb begin
        case (rd_addr)
            3'd0:    rd_d = snap_q[0];
            3'd1:    rd_d = snap_q[1];
            3'd2:    rd_d = snap_q[2];
            3'd3:    rd_d = snap_q[3];
            3'd4:    rd_d = snap_q[4];
            3'd5:    rd_d = snap_q[5];
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            cyc_q      <= '0;
            reason_q   <= 2'b00;
            rd_q       <= '0;
            sys_en_q   <= 1'b0;
            sys_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 6; i++) snap_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cyc_q      <= cyc_d;
            reason_q   <= reason_d;
            rd_q       <= rd_d;
            // Outputs are decoded from the next state so they are registered yet aligned to it.
            sys_en_q   <= (state_d == S_RUN);
            sys_rstn_q <= !((state_d == S_IDLE) || (state_d == S_CLEAR));
            busy_q     <= !((state_d == S_IDLE) || (state_d == S_DONE));
            done_q     <= (state_d == S_DONE);
            if (state_q == S_SNAP) begin
                snap_q[0] <= total_bits;
                snap_q[1] <= total_bit_errors_pre;
                snap_q[2] <= total_bit_errors_post;
                snap_q[3] <= total_frames;
                snap_q[4] <= total_frame_errors;
                snap_q[5] <= cyc_q;
            end
        end
    end

    assign sys_en      = sys_en_q;
    assign sys_rstn    = sys_rstn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stop_reason = reason_q;
    assign rd_data     = rd_q;

endmodule
